// File: rtl/radiant_trig_coinc_pkg.sv
// Shared constants, FSM encoding and helpers for the RADIANT coincidence trigger.
package radiant_trig_coinc_pkg;

    localparam int unsigned NumCh          = 24;
    localparam int unsigned DefWindowBits  = 5;
    localparam int unsigned DefHoldoffBits = 16;
    localparam int unsigned ThreshBits     = 5;
    localparam int unsigned TrigCountWidth = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFire    = 2'd1,
        StHoldoff = 2'd2
    } state_e;

    // Population count of one 8-channel group.
    function automatic logic [3:0] pop8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

endpackage

// File: rtl/radiant_trig_coinc_if.sv
// Static trigger configuration bundle from the trigger register block.
interface radiant_trig_coinc_if
    import radiant_trig_coinc_pkg::*;
#(
    parameter int unsigned WindowBits  = DefWindowBits,
    parameter int unsigned HoldoffBits = DefHoldoffBits
);
    logic [NumCh-1:0]       mask;       // 1 = channel excluded
    logic [WindowBits-1:0]  window;     // coincidence window, 0 treated as 1
    logic [ThreshBits-1:0]  thresh;     // majority, 0 disables coincidence
    logic [HoldoffBits-1:0] holdoff;    // dead cycles after a trigger
    logic                   enable;     // coincidence enable
    logic                   force_req;  // one-cycle software trigger

    modport master (
        output mask, window, thresh, holdoff, enable, force_req
    );

    modport slave (
        input mask, window, thresh, holdoff, enable, force_req
    );
endinterface

// File: rtl/radiant_trig_coinc_popcount24.sv
// Two-stage popcount over 24 active flags with a matching pattern delay.
module trig_popcount24
    import radiant_trig_coinc_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumCh-1:0]      active_i,
    input  logic [ThreshBits-1:0] thresh_i,
    output logic                  coinc_o,
    output logic [NumCh-1:0]      pattern_o
);
    logic [3:0]       grp_q [3];
    logic [NumCh-1:0] pattern_q;
    logic [4:0]       sum;

    // Stage 1: register three group sums and the pattern that produced them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int g = 0; g < 3; g++) grp_q[g] <= '0;
            pattern_q <= '0;
        end else begin
            for (int g = 0; g < 3; g++) grp_q[g] <= pop8(active_i[8*g +: 8]);
            pattern_q <= active_i;
        end
    end

    // Stage 2: total and majority compare, sampled by the FSM.
    always_comb begin
        sum       = {1'b0, grp_q[0]} + {1'b0, grp_q[1]} + {1'b0, grp_q[2]};
        coinc_o   = (thresh_i != '0) && (sum >= thresh_i);
        pattern_o = pattern_q;
    end
endmodule

// File: rtl/radiant_trig_coinc.sv
// Majority coincidence trigger with per-channel stretch, holdoff and software force.
module radiant_trig_coinc
    import radiant_trig_coinc_pkg::*;
#(
    parameter int unsigned WindowBits  = DefWindowBits,
    parameter int unsigned HoldoffBits = DefHoldoffBits,
    // Reset value of the trigger counter; nonzero only to exercise wrap.
    parameter logic [TrigCountWidth-1:0] CountInit = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumCh-1:0]          trig_i,
    radiant_trig_coinc_if.slave       cfg_i,
    output logic                      trig_o,
    output logic [NumCh-1:0]          trig_pattern_o,
    output logic [TrigCountWidth-1:0] trig_count_o,
    output logic                      busy_o
);
    logic [NumCh-1:0]          trig_q, trig_qq, rise, active, pattern;
    logic [WindowBits-1:0]     cnt_q [NumCh];
    logic [WindowBits-1:0]     cnt_d [NumCh];
    logic [WindowBits-1:0]     win_load;
    logic                      coinc, force_q;
    state_e                    state_q, state_d;
    logic [HoldoffBits-1:0]    hold_q, hold_d;
    logic                      fire_q, fire_d, busy_q, busy_d;
    logic [NumCh-1:0]          pat_q, pat_d;
    logic [TrigCountWidth-1:0] count_q, count_d;

    // Edge detect; reset to ones so levels high at reset release give no edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_q  <= '1;
            trig_qq <= '1;
            force_q <= 1'b0;
        end else begin
            trig_q  <= trig_i;
            trig_qq <= trig_q;
            force_q <= cfg_i.force_req;
        end
    end

    assign rise     = trig_q & ~trig_qq & ~cfg_i.mask;
    assign win_load = (cfg_i.window == '0) ? WindowBits'(1) : cfg_i.window;

    // Per-channel stretch counters; a new rise reloads a running window.
    always_comb begin
        for (int i = 0; i < NumCh; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!cfg_i.enable) begin
                cnt_d[i] = '0;
            end else if (rise[i]) begin
                cnt_d[i] = win_load;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - WindowBits'(1);
            end
            active[i] = (cnt_q[i] != '0);
        end
    end

    // Stretch counter state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumCh; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    trig_popcount24 u_popcount (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .active_i  (active),
        .thresh_i  (cfg_i.thresh),
        .coinc_o   (coinc),
        .pattern_o (pattern)
    );

    // FSM state and holdoff counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state; requests outside IDLE are dropped, not queued.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (coinc || force_q) state_d = StFire;
            end
            StFire: begin
                if (cfg_i.holdoff == '0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StHoldoff;
                    hold_d  = cfg_i.holdoff;
                end
            end
            StHoldoff: begin
                hold_d = hold_q - HoldoffBits'(1);
                if (hold_q <= HoldoffBits'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output next values, decoded from the next state so outputs are registered.
    always_comb begin
        fire_d  = (state_d == StFire);
        busy_d  = (state_d != StIdle);
        pat_d   = fire_d ? pattern : pat_q;
        count_d = fire_d ? count_q + TrigCountWidth'(1) : count_q;
    end

    // Output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fire_q  <= 1'b0;
            busy_q  <= 1'b0;
            pat_q   <= '0;
            count_q <= CountInit;
        end else begin
            fire_q  <= fire_d;
            busy_q  <= busy_d;
            pat_q   <= pat_d;
            count_q <= count_d;
        end
    end

    assign trig_o         = fire_q;
    assign busy_o         = busy_q;
    assign trig_pattern_o = pat_q;
    assign trig_count_o   = count_q;
endmodule

// File: tb/tb_radiant_trig_coinc.sv
// Directed bench for radiant_trig_coinc; a second instance starts its count near wrap.
module tb_radiant_trig_coinc;
    import radiant_trig_coinc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] trig;
    logic        trig_a, busy_a, trig_b, busy_b;
    logic [23:0] pat_a, pat_b;
    logic [31:0] cnt_a, cnt_b;
    logic [31:0] exp_cnt;
    int          errors = 0;
    int          checks = 0;

    radiant_trig_coinc_if cfg ();

    always #5 clk = ~clk;

    radiant_trig_coinc dut_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .trig_i         (trig),
        .cfg_i          (cfg),
        .trig_o         (trig_a),
        .trig_pattern_o (pat_a),
        .trig_count_o   (cnt_a),
        .busy_o         (busy_a)
    );

    radiant_trig_coinc #(.CountInit(32'hFFFF_FFFE)) dut_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .trig_i         (trig),
        .cfg_i          (cfg),
        .trig_o         (trig_b),
        .trig_pattern_o (pat_b),
        .trig_count_o   (cnt_b),
        .busy_o         (busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int n, output int pulses, output int busy_cycles);
        pulses = 0;
        busy_cycles = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (trig_a) pulses++;
            if (busy_a) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        int p, b;
        rst = 1'b1;
        trig = '1;
        cfg.enable = 1'b1; cfg.thresh = 5'd1; cfg.window = 5'd4; cfg.holdoff = 16'd2;
        repeat (3) step();
        checks++;
        if (trig_a !== 1'b0) begin errors++; $display("FAIL rst_trig got=%b exp=0", trig_a); end
        checks++;
        if (pat_a !== 24'h0) begin errors++; $display("FAIL rst_pattern got=%h exp=0", pat_a); end
        checks++;
        if (cnt_a !== 32'h0) begin errors++; $display("FAIL rst_count got=%h exp=0", cnt_a); end
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
        checks++;
        if (cnt_b !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL rst_count_preset got=%h exp=fffffffe", cnt_b);
        end
        rst = 1'b0;
        watch(10, p, b);
        checks++;
        if (p !== 0) begin errors++; $display("FAIL high_thru_reset pulses got=%0d exp=0", p); end
        trig = '0;
        repeat (5) step();
        exp_cnt = 32'd0;
    endtask

    task automatic test_coinc();
        int p, b;
        cfg.mask = '0; cfg.thresh = 5'd3; cfg.window = 5'd4; cfg.holdoff = 16'd10;
        cfg.enable = 1'b1;
        trig = 24'h000221;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (trig_a !== 1'b0) begin
                errors++; $display("FAIL coinc_early cyc=%0d got=%b exp=0", i, trig_a);
            end
        end
        step();
        exp_cnt = exp_cnt + 1;
        checks++;
        if (trig_a !== 1'b1) begin errors++; $display("FAIL coinc_fire got=%b exp=1", trig_a); end
        checks++;
        if (pat_a !== 24'h000221) begin
            errors++; $display("FAIL coinc_pattern got=%h exp=000221", pat_a);
        end
        checks++;
        if (cnt_a !== exp_cnt) begin
            errors++; $display("FAIL coinc_count got=%0d exp=%0d", cnt_a, exp_cnt);
        end
        watch(20, p, b);
        checks++;
        if (p !== 0) begin errors++; $display("FAIL coinc_single pulses got=%0d exp=0", p); end
        checks++;
        if (b + 1 !== 11) begin errors++; $display("FAIL coinc_busy cycles got=%0d exp=11", b + 1); end
        trig = '0;
        repeat (5) step();
    endtask

    task automatic test_window();
        int p, b;
        cfg.thresh = 5'd2; cfg.window = 5'd4; cfg.holdoff = 16'd2;
        for (int off = 3; off <= 4; off++) begin
            trig = 24'h000001;
            repeat (off) step();
            trig = 24'h000003;
            watch(12, p, b);
            if (off == 3) exp_cnt = exp_cnt + 1;
            checks++;
            if (p !== ((off == 3) ? 1 : 0)) begin
                errors++; $display("FAIL window_off%0d pulses got=%0d exp=%0d", off, p,
                                   (off == 3) ? 1 : 0);
            end
            checks++;
            if (cnt_a !== exp_cnt) begin
                errors++; $display("FAIL window_count off%0d got=%0d exp=%0d", off, cnt_a, exp_cnt);
            end
            trig = '0;
            repeat (8) step();
        end
    endtask

    task automatic test_mask();
        int p, b;
        cfg.mask = 24'h000008; cfg.thresh = 5'd2; cfg.window = 5'd4;
        trig = 24'h000018;
        watch(10, p, b);
        checks++;
        if (p !== 0) begin errors++; $display("FAIL mask_block pulses got=%0d exp=0", p); end
        trig = '0;
        repeat (6) step();
        cfg.mask = '0; cfg.thresh = 5'd0;
        trig = '1;
        watch(10, p, b);
        checks++;
        if (p !== 0) begin errors++; $display("FAIL thresh_zero pulses got=%0d exp=0", p); end
        checks++;
        if (cnt_a !== exp_cnt) begin
            errors++; $display("FAIL mask_count got=%0d exp=%0d", cnt_a, exp_cnt);
        end
        trig = '0;
        repeat (6) step();
    endtask

    task automatic test_force();
        int p, b;
        cfg.enable = 1'b0; cfg.thresh = 5'd3; cfg.holdoff = 16'd10;
        cfg.force_req = 1'b1;
        step();
        cfg.force_req = 1'b0;
        checks++;
        if (trig_a !== 1'b0) begin errors++; $display("FAIL force_early got=%b exp=0", trig_a); end
        step();
        exp_cnt = exp_cnt + 1;
        checks++;
        if (trig_a !== 1'b1) begin errors++; $display("FAIL force_fire got=%b exp=1", trig_a); end
        checks++;
        if (cnt_a !== exp_cnt) begin
            errors++; $display("FAIL force_count got=%0d exp=%0d", cnt_a, exp_cnt);
        end
        checks++;
        if (pat_a !== 24'h0) begin errors++; $display("FAIL force_pattern got=%h exp=0", pat_a); end
        repeat (3) step();
        cfg.force_req = 1'b1;
        step();
        cfg.force_req = 1'b0;
        watch(15, p, b);
        checks++;
        if (p !== 0) begin errors++; $display("FAIL force_in_holdoff pulses got=%0d exp=0", p); end
        checks++;
        if (cnt_a !== exp_cnt) begin
            errors++; $display("FAIL force_ignored_count got=%0d exp=%0d", cnt_a, exp_cnt);
        end
    endtask

    task automatic test_reset_holdoff();
        cfg.holdoff = 16'd20;
        cfg.force_req = 1'b1;
        step();
        cfg.force_req = 1'b0;
        repeat (6) step();
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL holdoff_busy got=%b exp=1", busy_a); end
        rst = 1'b1;
        step();
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
        checks++;
        if (cnt_a !== 32'h0) begin errors++; $display("FAIL abort_count got=%h exp=0", cnt_a); end
        checks++;
        if (cnt_b !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL abort_count_preset got=%h exp=fffffffe", cnt_b);
        end
        rst = 1'b0;
        step();
        exp_cnt = 32'd0;
    endtask

    task automatic test_back_to_back();
        int p, b;
        logic [31:0] first_b;
        p = 0;
        b = 0;
        first_b = 32'h0;
        cfg.holdoff = 16'd0;
        cfg.force_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 3) cfg.force_req = 1'b0;
            if (trig_a) begin
                if (p == 0) first_b = cnt_b;
                p++;
            end
            if (busy_a) b++;
        end
        checks++;
        if (p !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", p); end
        checks++;
        if (b !== 2) begin errors++; $display("FAIL b2b_busy got=%0d exp=2", b); end
        checks++;
        if (cnt_a !== 32'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", cnt_a); end
        checks++;
        if (first_b !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wrap_pre got=%h exp=ffffffff", first_b);
        end
        checks++;
        if (cnt_b !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", cnt_b); end
    endtask

    initial begin
        rst = 1'b1;
        trig = '0;
        exp_cnt = '0;
        cfg.mask = '0; cfg.window = 5'd4; cfg.thresh = 5'd0; cfg.holdoff = 16'd0;
        cfg.enable = 1'b0; cfg.force_req = 1'b0;
        test_reset();
        test_coinc();
        test_window();
        test_mask();
        test_force();
        test_reset_holdoff();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
